// File: rtl/ramen_timer_pkg.sv
// Shared types and helpers for the ramen countdown timer.
//   state_t      : controller state encoding, also driven out on state_o
//   bcd_digit_t  : one BCD digit
//   PRESET_W     : width of the binary preset-minutes register
//   bcd_dec_mmss : MM:SS BCD minus one second (caller guarantees not 00:00)
//   bin2bcd      : binary minutes to {tens,units} BCD
package ramen_timer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    PAUSE  = 3'd2,
    TIMEUP = 3'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int PRESET_W = 7;

  function automatic logic [15:0] bcd_dec_mmss(input logic [7:0] mm,
                                               input logic [7:0] ss);
    bcd_digit_t mt, mu, st, su;
    {mt, mu} = mm;
    {st, su} = ss;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      su = 4'd9;
    end else begin
      // seconds wrap 00 -> 59 and borrow one minute
      st = 4'd5;
      su = 4'd9;
      if (mu != 4'd0) begin
        mu = mu - 4'd1;
      end else begin
        mt = mt - 4'd1;
        mu = 4'd9;
      end
    end
    return {mt, mu, st, su};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [PRESET_W-1:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/ramen_timer_ctrl_if.sv
// Key / tick / display bundle between the board-side stimulus and the timer
// controller.
//   key_n          : raw active-low keys, [0] start/pause, [1] set/cancel
//   tick_1s        : one-cycle pulse per second
//   run_en         : high while counting
//   remain_min_bcd : remaining minutes {tens,units}
//   remain_sec_bcd : remaining seconds {tens,units}
//   state_o        : controller state encoding
//   timeup         : high while in TIMEUP
//   alarm_blink    : toggles per tick in TIMEUP
// master drives keys and tick, slave (the controller) drives the rest.
interface ramen_timer_ctrl_if;
  logic [1:0] key_n;
  logic       tick_1s;
  logic       run_en;
  logic [7:0] remain_min_bcd;
  logic [7:0] remain_sec_bcd;
  logic [2:0] state_o;
  logic       timeup;
  logic       alarm_blink;

  modport master (
    output key_n, tick_1s,
    input  run_en, remain_min_bcd, remain_sec_bcd, state_o, timeup, alarm_blink
  );

  modport slave (
    input  key_n, tick_1s,
    output run_en, remain_min_bcd, remain_sec_bcd, state_o, timeup, alarm_blink
  );
endinterface

// File: rtl/ramen_timer_ctrl_key_debounce.sv
// Single-key debouncer.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_n      : raw asynchronous active-low key
//   press      : one-cycle pulse on a debounced press (high-to-low)
// A new level is accepted only after the synchronised input has differed
// from the current debounced level for CLK_FREQ_KHZ*DEBOUNCE_MS cycles.
module key_debounce #(
  parameter int CLK_FREQ_KHZ = 50000,
  parameter int DEBOUNCE_MS  = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  import ramen_timer_pkg::*;

  localparam int N  = (CLK_FREQ_KHZ * DEBOUNCE_MS < 1) ? 1 : CLK_FREQ_KHZ * DEBOUNCE_MS;
  localparam int CW = (N < 2) ? 1 : $clog2(N);

  logic          sync1, sync2, level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CW'(N - 1)) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2;  // only the falling edge is an event
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;  // any bounce back restarts the window
      end
    end
  end

endmodule

// File: rtl/ramen_timer_ctrl.sv
// Ramen countdown timer controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : keys and 1 s tick in; remaining MM:SS BCD, state, run_en,
//                timeup and alarm_blink out (all registered)
// Two debounced keys set the preset and start/pause/cancel a countdown that
// advances on tick_1s; reaching 00:00 enters TIMEUP, which blinks the alarm
// for ALARM_SEC ticks or until a key event, then returns to IDLE.
module ramen_timer_ctrl
  import ramen_timer_pkg::*;
#(
  parameter int CLK_FREQ_KHZ       = 50000,
  parameter int DEBOUNCE_MS        = 20,
  parameter int PRESET_MIN_DEFAULT = 3,
  parameter int MAX_MIN            = 59,
  parameter int ALARM_SEC          = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  ramen_timer_ctrl_if.slave  bus
);

  localparam int TC_W = (ALARM_SEC < 2) ? 1 : $clog2(ALARM_SEC);

  state_t                state;
  logic [PRESET_W-1:0]   preset, preset_inc;
  logic [7:0]            rmin, rsec;
  logic                  run_en_q, timeup_q, blink_q;
  logic [TC_W-1:0]       tick_cnt;
  logic                  ev0, ev1;
  logic [15:0]           dec;
  logic                  at_zero, dec_zero;

  key_debounce #(.CLK_FREQ_KHZ(CLK_FREQ_KHZ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_deb0 (
    .clk(clk), .rst_n(rst_n), .key_n(bus.key_n[0]), .press(ev0)
  );
  key_debounce #(.CLK_FREQ_KHZ(CLK_FREQ_KHZ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_deb1 (
    .clk(clk), .rst_n(rst_n), .key_n(bus.key_n[1]), .press(ev1)
  );

  always_comb begin
    preset_inc = (preset >= PRESET_W'(MAX_MIN)) ? PRESET_W'(1) : preset + PRESET_W'(1);
    dec        = bcd_dec_mmss(rmin, rsec);
    at_zero    = (rmin == 8'h00) && (rsec == 8'h00);
    dec_zero   = (dec == 16'h0000);
  end

  // Key1 is tested before key0 everywhere so it wins on simultaneous events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      preset   <= PRESET_W'(PRESET_MIN_DEFAULT);
      rmin     <= bin2bcd(PRESET_W'(PRESET_MIN_DEFAULT));
      rsec     <= 8'h00;
      run_en_q <= 1'b0;
      timeup_q <= 1'b0;
      blink_q  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsec <= 8'h00;
          if (ev1) begin
            preset <= preset_inc;
            rmin   <= bin2bcd(preset_inc);
          end else begin
            rmin <= bin2bcd(preset);
            if (ev0) begin
              state    <= RUN;
              run_en_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.tick_1s && !at_zero) begin
            {rmin, rsec} <= dec;
          end
          // expiry beats any key taken in the same cycle
          if (bus.tick_1s && !at_zero && dec_zero) begin
            state    <= TIMEUP;
            run_en_q <= 1'b0;
            timeup_q <= 1'b1;
            blink_q  <= 1'b0;
            tick_cnt <= '0;
          end else if (ev1) begin
            state    <= IDLE;
            run_en_q <= 1'b0;
            rmin     <= bin2bcd(preset);
            rsec     <= 8'h00;
          end else if (ev0) begin
            state    <= PAUSE;
            run_en_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (ev1) begin
            state <= IDLE;
            rmin  <= bin2bcd(preset);
            rsec  <= 8'h00;
          end else if (ev0) begin
            state    <= RUN;
            run_en_q <= 1'b1;
          end
        end
        TIMEUP: begin
          rmin <= 8'h00;
          rsec <= 8'h00;
          if (ev0 || ev1 || (bus.tick_1s && (tick_cnt == TC_W'(ALARM_SEC - 1)))) begin
            state    <= IDLE;
            timeup_q <= 1'b0;
            blink_q  <= 1'b0;
            tick_cnt <= '0;
            rmin     <= bin2bcd(preset);
          end else if (bus.tick_1s) begin
            blink_q  <= ~blink_q;
            tick_cnt <= tick_cnt + TC_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          run_en_q <= 1'b0;
          timeup_q <= 1'b0;
          blink_q  <= 1'b0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.run_en         = run_en_q;
  assign bus.remain_min_bcd = rmin;
  assign bus.remain_sec_bcd = rsec;
  assign bus.state_o        = state;
  assign bus.timeup         = timeup_q;
  assign bus.alarm_blink    = blink_q;

endmodule

// File: tb/tb_ramen_timer_ctrl.sv
// Directed bench for ramen_timer_ctrl with a 4-cycle debounce window.
// Expected values are queued as each step is driven and popped as the
// corresponding DUT output is sampled one time unit after the clock edge.
module tb_ramen_timer_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_PAUSE = 3'd2, S_TIMEUP = 3'd3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ramen_timer_ctrl_if bus ();

  ramen_timer_ctrl #(
    .CLK_FREQ_KHZ(1), .DEBOUNCE_MS(4), .PRESET_MIN_DEFAULT(3), .MAX_MIN(59), .ALARM_SEC(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [31:0] mmss(input int secs);
    return {16'h0, to_bcd(secs / 60), to_bcd(secs % 60)};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $error("FAIL sb_underflow observed=%h expected=none", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] obs_state();
    return {29'h0, bus.state_o};
  endfunction

  function automatic logic [31:0] obs_remain();
    return {16'h0, bus.remain_min_bcd, bus.remain_sec_bcd};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    bus.tick_1s = 1'b1;
    step(1);
    bus.tick_1s = 1'b0;
    step(1);
  endtask

  task automatic press(input int k);
    bus.key_n[k] = 1'b0;
    step(12);
    bus.key_n[k] = 1'b1;
    step(12);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int rem;
    int p;
    int toggles;
    logic prev;

    bus.key_n   = 2'b11;
    bus.tick_1s = 1'b0;
    rst_n       = 1'b0;
    step(3);

    // reset release
    push("rst_state", 32'(S_IDLE));
    push("rst_remain", 32'h0300);
    push("rst_run_en", 32'd0);
    push("rst_timeup", 32'd0);
    push("rst_blink", 32'd0);
    rst_n = 1'b1;
    step(2);
    pop_check(obs_state());
    pop_check(obs_remain());
    pop_check(32'(bus.run_en));
    pop_check(32'(bus.timeup));
    pop_check(32'(bus.alarm_blink));

    // start, count, pause, resume
    rem = 180;
    push("start_state", 32'(S_RUN));
    push("start_run_en", 32'd1);
    press(0);
    pop_check(obs_state());
    pop_check(32'(bus.run_en));
    for (int i = 0; i < 3; i++) begin
      rem--;
      push("run_dec", mmss(rem));
      tick1();
      pop_check(obs_remain());
    end
    push("pause_state", 32'(S_PAUSE));
    press(0);
    pop_check(obs_state());
    for (int i = 0; i < 2; i++) begin
      push("pause_hold", mmss(rem));
      tick1();
      pop_check(obs_remain());
    end
    push("resume_state", 32'(S_RUN));
    press(0);
    pop_check(obs_state());

    // 2-cycle glitch is filtered
    push("glitch_state", 32'(S_RUN));
    bus.key_n[0] = 1'b0;
    step(2);
    bus.key_n[0] = 1'b1;
    step(12);
    pop_check(obs_state());

    // both keys together: cancel wins
    push("both_state", 32'(S_IDLE));
    push("both_remain", 32'h0300);
    bus.key_n = 2'b00;
    step(12);
    bus.key_n = 2'b11;
    step(12);
    pop_check(obs_state());
    pop_check(obs_remain());

    // preset increments through 59 and wraps to 1
    p = 3;
    for (int i = 1; i <= 57; i++) begin
      p = (p == 59) ? 1 : p + 1;
      if (i >= 56) push("preset_inc", 32'(to_bcd(p)));
      press(1);
      if (i >= 56) pop_check(32'(bus.remain_min_bcd));
    end

    // full one-minute countdown
    push("cd_start", 32'(S_RUN));
    press(0);
    pop_check(obs_state());
    rem = 60;
    for (int i = 1; i <= 60; i++) begin
      rem--;
      push("cd_remain", mmss(rem));
      if (rem == 0) begin
        push("cd_timeup", 32'd1);
        push("cd_state", 32'(S_TIMEUP));
      end
      tick1();
      pop_check(obs_remain());
      if (rem == 0) begin
        pop_check(32'(bus.timeup));
        pop_check(obs_state());
      end
    end

    // alarm blinks for ten ticks then returns to IDLE
    toggles = 0;
    prev = bus.alarm_blink;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) push("alarm_hold", 32'(S_TIMEUP));
      tick1();
      if (bus.alarm_blink !== prev) toggles++;
      prev = bus.alarm_blink;
      if (i == 8) pop_check(obs_state());
    end
    push("alarm_toggles", 32'd10);
    push("alarm_end_state", 32'(S_IDLE));
    push("alarm_end_remain", 32'h0100);
    push("alarm_end_blink", 32'd0);
    push("alarm_end_timeup", 32'd0);
    pop_check(32'(toggles));
    pop_check(obs_state());
    pop_check(obs_remain());
    pop_check(32'(bus.alarm_blink));
    pop_check(32'(bus.timeup));

    // tick and key0 event together at 00:01
    push("sim_start", 32'(S_RUN));
    press(0);
    pop_check(obs_state());
    for (int i = 0; i < 59; i++) tick1();
    push("sim_pre", 32'h0001);
    pop_check(obs_remain());
    push("sim_state", 32'(S_TIMEUP));
    push("sim_remain", 32'h0000);
    bus.key_n[0] = 1'b0;
    step(6);
    bus.tick_1s = 1'b1;
    step(1);
    bus.tick_1s = 1'b0;
    step(5);
    bus.key_n[0] = 1'b1;
    step(12);
    pop_check(obs_state());
    pop_check(obs_remain());

    // key event exits TIMEUP
    push("exit_state", 32'(S_IDLE));
    push("exit_remain", 32'h0100);
    press(1);
    pop_check(obs_state());
    pop_check(obs_remain());

    // asynchronous reset mid-count
    push("mid_start", 32'(S_RUN));
    press(0);
    pop_check(obs_state());
    tick1();
    tick1();
    push("mid_remain", 32'h0058);
    pop_check(obs_remain());
    push("arst_state", 32'(S_IDLE));
    push("arst_remain", 32'h0300);
    push("arst_run_en", 32'd0);
    rst_n = 1'b0;
    #1;
    pop_check(obs_state());
    pop_check(obs_remain());
    pop_check(32'(bus.run_en));
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
